// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   MEM-stage initiator. Splits one 32-bit pipeline load/store into four
//   byte-wide req/ack beats on a byte-organised data-memory port. Load bytes
//   are assembled little-endian. The pipeline is stalled while the access runs.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     When defined, a per-beat ack-wait counter aborts the access after
//     TIMEOUT_CYCLES cycles without ack. It also sets a sticky err_o flag.
//     A timed-out load returns 32'hDEADBEEF.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   memRead_i    load request level (held while stall_o)
//   memWrite_i   store request level (held while stall_o); wins over load
//   addr_i       byte address of the word
//   wdata_i      store data
//   rdata_o      assembled load data (holds between loads)
//   stall_o      pipeline freeze (combinational)
//   done_o       one-cycle completion pulse
//   mem_req_o    byte request
//   mem_we_o     1 = write beat
//   mem_addr_o   byte address of current beat (wraps modulo 2^ADDR_W)
//   mem_wdata_o  write byte of current beat
//   mem_ack_i    memory accepts beat (read byte valid same cycle)
//   mem_rdata_i  read byte
//   err_o        sticky timeout flag (LSU_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              memRead_i,
  input  logic              memWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i
`ifdef LSU_TIMEOUT_EN
  ,
  output logic              err_o
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Byte lane k of a word.
  function automatic logic [7:0] selectByte(input logic [31:0] word, input logic [1:0] idx);
    selectByte = word[{idx, 3'b000} +: 8];
  endfunction

  // Replace byte lane k of a word.
  function automatic logic [31:0] insertByte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] data);
    logic [31:0] tmp;
    tmp = word;
    tmp[{idx, 3'b000} +: 8] = data;
    insertByte = tmp;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        beat_r;
  logic              opWrite_r;
  logic [31:0]       wdata_r;
  logic [31:0]       shadow_r;
  logic [31:0]       rdata_r;
  logic              done_r;
  logic              memReq_r;
  logic              memWe_r;
  logic [ADDR_W-1:0] memAddr_r;
  logic [7:0]        memWdata_r;
  logic              ackTake_s;
  logic              timeoutHit_s;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] toCnt_r;
  logic             err_r;

  // Timeout fires on the last permitted ack-less cycle of a beat.
  always_comb begin
    timeoutHit_s = (state_r == ACCESS) && memReq_r && !mem_ack_i &&
                   (toCnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Per-beat wait counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      toCnt_r <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else if (state_r != ACCESS || ackTake_s) begin
      toCnt_r <= {CNT_W{1'b0}};
    end else if (timeoutHit_s) begin
      toCnt_r <= {CNT_W{1'b0}};
      err_r   <= 1'b1;
    end else begin
      toCnt_r <= toCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_o = err_r;

  // Only the memory-port byte-address bits are used from addr_i.
  logic unusedBits_s;
  assign unusedBits_s = ^addr_i[31:ADDR_W];
`else
  // Without the watchdog an access simply waits for ack.
  always_comb begin
    timeoutHit_s = 1'b0;
  end

  logic unusedBits_s;
  assign unusedBits_s = ^{addr_i[31:ADDR_W], TIMEOUT_CYCLES[0]};
`endif

  // A beat completes only while a request is actually outstanding.
  always_comb begin
    ackTake_s = (state_r == ACCESS) && memReq_r && mem_ack_i;
  end

  // Stall while a request waits in IDLE or an access is in flight; released in DONE.
  always_comb begin
    stall_o = ((state_r == IDLE) && (memRead_i || memWrite_i)) || (state_r == ACCESS);
  end

  // Access sequencer: beat stepping, shadow-word assembly and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      beat_r     <= 2'd0;
      opWrite_r  <= 1'b0;
      wdata_r    <= 32'd0;
      shadow_r   <= 32'd0;
      rdata_r    <= 32'd0;
      done_r     <= 1'b0;
      memReq_r   <= 1'b0;
      memWe_r    <= 1'b0;
      memAddr_r  <= {ADDR_W{1'b0}};
      memWdata_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (memWrite_i || memRead_i) begin
            opWrite_r  <= memWrite_i;
            wdata_r    <= wdata_i;
            beat_r     <= 2'd0;
            memReq_r   <= 1'b1;
            memWe_r    <= memWrite_i;
            memAddr_r  <= addr_i[ADDR_W-1:0];
            memWdata_r <= wdata_i[7:0];
            state_r    <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (ackTake_s) begin
            if (!opWrite_r) begin
              shadow_r <= insertByte(shadow_r, beat_r, mem_rdata_i);
            end
            if (beat_r == 2'd3) begin
              memReq_r <= 1'b0;
              memWe_r  <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end else begin
              beat_r     <= beat_r + 2'd1;
              // Address wraps naturally at the port width.
              memAddr_r  <= memAddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              memWdata_r <= selectByte(wdata_r, beat_r + 2'd1);
            end
          end else if (timeoutHit_s) begin
            if (!opWrite_r) begin
              shadow_r <= 32'hDEADBEEF;
            end
            memReq_r <= 1'b0;
            memWe_r  <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r <= ACCESS;
          end
        end
        DONE: begin
          // Requests seen here belong to the retiring instruction.
          if (!opWrite_r) begin
            rdata_r <= shadow_r;
          end
          state_r <= IDLE;
        end
        default: begin
          memReq_r <= 1'b0;
          memWe_r  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign rdata_o     = rdata_r;
  assign done_o      = done_r;
  assign mem_req_o   = memReq_r;
  assign mem_we_o    = memWe_r;
  assign mem_addr_o  = memAddr_r;
  assign mem_wdata_o = memWdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addrIn;
  logic [31:0] wdataIn;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        memReq;
  logic        memWe;
  logic [4:0]  memAddr;
  logic [7:0]  memWdata;
  logic        memAck;
  logic [7:0]  memRdata;
`ifdef LSU_TIMEOUT_EN
  logic        err;
`endif

  load_store_unit #(.ADDR_W(5), .TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .memRead_i   (memRead),
    .memWrite_i  (memWrite),
    .addr_i      (addrIn),
    .wdata_i     (wdataIn),
    .rdata_o     (rdata),
    .stall_o     (stall),
    .done_o      (done),
    .mem_req_o   (memReq),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_ack_i   (memAck),
    .mem_rdata_i (memRdata)
`ifdef LSU_TIMEOUT_EN
    ,
    .err_o       (err)
`endif
  );

  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;

  logic [7:0] mem [0:31];
  logic [7:0] beatAddr [0:7];
  logic [7:0] beatData [0:7];
  logic       beatWe   [0:7];

  int          doneCyc;
  int          stallCnt;
  int          nBeats;
  int          unstable;
  logic [31:0] rdAfter;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access with a byte-memory responder that acks each beat after `waits` idle cycles.
  task automatic doAccess(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input int budget,
                          output int dc, output int sc, output int nb, output int us,
                          output logic [31:0] ra);
    int waitCnt;
    logic [4:0] hA;
    logic [7:0] hD;
    logic       hW;
    dc = -1; sc = 0; nb = 0; us = 0; waitCnt = 0;
    hA = 5'd0; hD = 8'd0; hW = 1'b0;
    @(negedge clk);
    memRead = rd; memWrite = wr; addrIn = a; wdataIn = wd; memAck = 1'b0;
    #1;
    if (stall) sc++;
    for (int c = 1; c <= budget && dc < 0; c++) begin
      @(negedge clk);
      memAck = 1'b0;
      memRdata = 8'h5A;
      if (stall) sc++;
      if (done) begin
        dc = c;
        memRead = 1'b0;
        memWrite = 1'b0;
      end else if (memReq) begin
        if (waitCnt == 0) begin
          hA = memAddr; hD = memWdata; hW = memWe;
        end else if (memAddr != hA || memWdata != hD || memWe != hW) begin
          us++;
        end
        if (waitCnt == waits) begin
          memAck = 1'b1;
          if (nb < 8) begin
            beatAddr[nb] = {3'b000, memAddr};
            beatData[nb] = memWdata;
            beatWe[nb]   = memWe;
          end
          if (memWe) mem[memAddr] = memWdata;
          else       memRdata = mem[memAddr];
          nb++;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end
    end
    memRead = 1'b0;
    memWrite = 1'b0;
    memAck = 1'b0;
    checkValue("access_completed", {31'd0, dc > 0}, 32'd1);
    @(negedge clk);
    checkValue("done_single_pulse", {31'd0, done}, 32'd0);
    ra = rdata;
  endtask

  initial begin
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; addrIn = 32'd0; wdataIn = 32'd0;
    memAck = 1'b0; memRdata = 8'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[30] = 8'hA0; mem[31] = 8'hA1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("rst_req",   {31'd0, memReq}, 32'd0);
    checkValue("rst_we",    {31'd0, memWe}, 32'd0);
    checkValue("rst_addr",  {27'd0, memAddr}, 32'd0);
    checkValue("rst_wdata", {24'd0, memWdata}, 32'd0);
    checkValue("rst_rdata", rdata, 32'd0);
    checkValue("rst_done",  {31'd0, done}, 32'd0);
    checkValue("rst_stall", {31'd0, stall}, 32'd0);
`ifdef LSU_TIMEOUT_EN
    checkValue("rst_err",   {31'd0, err}, 32'd0);
`endif

    // Zero-wait load at address 4.
    doAccess(1'b1, 1'b0, 32'd4, 32'd0, 0, 40, doneCyc, stallCnt, nBeats, unstable, rdAfter);
    checkValue("ld4_done_cycle", doneCyc, 32'd5);
    checkValue("ld4_stall_cycles", stallCnt, 32'd5);
    checkValue("ld4_beats", nBeats, 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkValue($sformatf("ld4_addr%0d", k), {24'd0, beatAddr[k]}, 32'd4 + k);
      checkValue($sformatf("ld4_we%0d", k), {31'd0, beatWe[k]}, 32'd0);
    end
    checkValue("ld4_rdata", rdAfter, 32'h44332211);

    // Store at 8 with two wait cycles per beat.
    doAccess(1'b0, 1'b1, 32'd8, 32'hA1B2C3D4, 2, 80, doneCyc, stallCnt, nBeats, unstable, rdAfter);
    checkValue("st8_done_cycle", doneCyc, 32'd13);
    checkValue("st8_stall_cycles", stallCnt, 32'd13);
    checkValue("st8_stable", unstable, 32'd0);
    checkValue("st8_addr0", {24'd0, beatAddr[0]}, 32'd8);
    checkValue("st8_addr3", {24'd0, beatAddr[3]}, 32'd11);
    checkValue("st8_data0", {24'd0, beatData[0]}, 32'h000000D4);
    checkValue("st8_data1", {24'd0, beatData[1]}, 32'h000000C3);
    checkValue("st8_data2", {24'd0, beatData[2]}, 32'h000000B2);
    checkValue("st8_data3", {24'd0, beatData[3]}, 32'h000000A1);
    checkValue("st8_we3", {31'd0, beatWe[3]}, 32'd1);
    checkValue("st8_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hA1B2C3D4);
    checkValue("st8_rdata_kept", rdAfter, 32'h44332211);

    // Read and write together: the write wins.
    doAccess(1'b1, 1'b1, 32'd0, 32'h55667788, 0, 40, doneCyc, stallCnt, nBeats, unstable, rdAfter);
    checkValue("rw_we0", {31'd0, beatWe[0]}, 32'd1);
    checkValue("rw_we2", {31'd0, beatWe[2]}, 32'd1);
    checkValue("rw_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h55667788);
    checkValue("rw_rdata_kept", rdAfter, 32'h44332211);

    // Load at 30 wraps to 0 and 1.
    doAccess(1'b1, 1'b0, 32'd30, 32'd0, 1, 60, doneCyc, stallCnt, nBeats, unstable, rdAfter);
    checkValue("ld30_addr0", {24'd0, beatAddr[0]}, 32'd30);
    checkValue("ld30_addr1", {24'd0, beatAddr[1]}, 32'd31);
    checkValue("ld30_addr2", {24'd0, beatAddr[2]}, 32'd0);
    checkValue("ld30_addr3", {24'd0, beatAddr[3]}, 32'd1);
    checkValue("ld30_rdata", rdAfter, 32'h7788A1A0);

    // Reset after the beat-1 ack aborts the access.
    @(negedge clk);
    memRead = 1'b1; addrIn = 32'd16; memAck = 1'b0;
    @(negedge clk);
    memAck = 1'b1; memRdata = 8'h99;
    @(negedge clk);
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkValue("abort_req", {31'd0, memReq}, 32'd0);
    checkValue("abort_rdata", rdata, 32'd0);
    checkValue("abort_done", {31'd0, done}, 32'd0);
    checkValue("abort_stall_req", {31'd0, stall}, 32'd1);
    memRead = 1'b0;
    #1;
    checkValue("abort_stall_idle", {31'd0, stall}, 32'd0);
    rst = 1'b0; memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkValue("late_ack_req", {31'd0, memReq}, 32'd0);
    checkValue("late_ack_done", {31'd0, done}, 32'd0);
    checkValue("late_ack_stall", {31'd0, stall}, 32'd0);
    checkValue("late_ack_rdata", rdata, 32'd0);
    @(negedge clk);
    checkValue("late_ack_done2", {31'd0, done}, 32'd0);

`ifdef LSU_TIMEOUT_EN
    // Load with ack never arriving.
    doAccess(1'b1, 1'b0, 32'd12, 32'd0, 1000, 200, doneCyc, stallCnt, nBeats, unstable, rdAfter);
    checkValue("to_done_cycle", doneCyc, 32'd17);
    checkValue("to_beats", nBeats, 32'd0);
    checkValue("to_err", {31'd0, err}, 32'd1);
    checkValue("to_rdata", rdAfter, 32'hDEADBEEF);
`endif

    // Clean load after recovery.
    doAccess(1'b1, 1'b0, 32'd4, 32'd0, 0, 40, doneCyc, stallCnt, nBeats, unstable, rdAfter);
    checkValue("reld4_rdata", rdAfter, 32'h44332211);
    checkValue("reld4_done_cycle", doneCyc, 32'd5);
`ifdef LSU_TIMEOUT_EN
    checkValue("reld4_err_sticky", {31'd0, err}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
